mem_loader: RTL



---
 rtl/loader_pkg.sv | 25 ++
 rtl/loader_checksum.sv | 41 ++++
 rtl/mem_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the program-memory loader: FSM state
//               encoding, width of the remaining-byte counter (a length byte
//               of 0 stands for 256, so it needs 9 bits) and the default
//               first address written by a frame.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int LEN_ZERO_MEANS_256 = 9;

    localparam logic [7:0] DEFAULT_LOAD_BASE = 8'h00;

    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_DATA     = 3'd1;
    localparam logic [2:0] c_CHECK    = 3'd2;
    localparam logic [2:0] c_DONE     = 3'd3;
    localparam logic [2:0] c_ERROR    = 3'd4;
    localparam logic [2:0] c_FINISH   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// ============================================================================
// Module      : loader_checksum
// Description : 8-bit running sum of payload bytes (mod 256) with a
//               synchronous clear, plus an equality compare against a
//               candidate checksum byte.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               i_clear    - zero the sum (start of a frame)
//               i_addEn    - add i_addData to the sum
//               i_addData  - payload byte
//               i_cmpData  - byte to compare with the current sum
//               o_match    - i_cmpData equals the current sum
// Revision    : 1.0 - initial release
// ============================================================================
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_addEn,
    input  logic [7:0] i_addData,
    input  logic [7:0] i_cmpData,
    output logic       o_match
);

    logic [7:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else if (i_clear) begin
            r_sum <= 8'h00;
        end else if (i_addEn) begin
            r_sum <= r_sum + i_addData;
        end
    end

    assign o_match = (r_sum == i_cmpData);

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Loads the 256-byte program memory from a framed byte stream
//               (length, payload[, checksum]) and releases the CPU once a
//               frame has been completely and correctly written.
// Build macro : MEM_LOADER_CHECKSUM_EN - frame carries a trailing checksum
//               byte; mismatches raise loadError. Undefined: no checksum
//               byte, loadError tied 0.
// Parameters  : LOAD_BASE      - first address written by every frame
// Ports       : clk            - system clock
//               reset          - asynchronous active-high reset
//               inData         - stream byte
//               inValid        - inData valid this cycle
//               inReady        - loader can take a byte this cycle
//               memAddr        - write address
//               memDataWrite   - write data
//               memWriteStrobe - one-cycle write enable
//               cpuRun         - CPU may fetch
//               loadError      - last frame failed its checksum (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] LOAD_BASE = DEFAULT_LOAD_BASE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] inData,
    input  logic       inValid,
    output logic       inReady,
    output logic [7:0] memAddr,
    output logic [7:0] memDataWrite,
    output logic       memWriteStrobe,
    output logic       cpuRun,
    output logic       loadError
);

    localparam int CNT_W = LEN_ZERO_MEANS_256;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_256 = CNT_W'(256);

    logic [c_STATE_W-1:0] r_state;
    logic [7:0]           r_addr;
    logic [CNT_W-1:0]     r_count;

    logic             w_xfer;
    logic             w_startFrame;
    logic             w_addByte;
    logic [CNT_W-1:0] w_lenCount;

    // Combinational so that the handshake drops the instant reset rises.
    assign inReady = ~reset & (r_state != c_FINISH);
    assign w_xfer  = inValid & inReady;

    // Any of IDLE/DONE/ERROR treats an accepted byte as a new length.
    assign w_startFrame = w_xfer & ((r_state == c_IDLE) || (r_state == c_DONE) ||
                                    (r_state == c_ERROR));
    assign w_addByte    = w_xfer & (r_state == c_DATA);
    assign w_lenCount   = (inData == 8'h00) ? c_CNT_256 : CNT_W'(inData);

`ifdef MEM_LOADER_CHECKSUM_EN
    logic w_sumMatch;
    logic r_loadError;

    loader_checksum u_checksum (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_startFrame),
        .i_addEn   (w_addByte),
        .i_addData (inData),
        .i_cmpData (inData),
        .o_match   (w_sumMatch)
    );

    assign loadError = r_loadError;
`else
    assign loadError = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_addr         <= 8'h00;
            r_count        <= '0;
            memAddr        <= 8'h00;
            memDataWrite   <= 8'h00;
            memWriteStrobe <= 1'b0;
            cpuRun         <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            r_loadError    <= 1'b0;
`endif
        end else begin
            memWriteStrobe <= 1'b0;
            if (w_startFrame) begin
                r_count <= w_lenCount;
                r_addr  <= LOAD_BASE;
                cpuRun  <= 1'b0;
                r_state <= c_DATA;
`ifdef MEM_LOADER_CHECKSUM_EN
                r_loadError <= 1'b0;
`endif
            end else begin
                case (r_state)
                    c_DATA: begin
                        if (w_xfer) begin
                            memAddr        <= r_addr;
                            memDataWrite   <= inData;
                            memWriteStrobe <= 1'b1;
                            r_addr         <= r_addr + 8'h01;
                            r_count        <= r_count - c_CNT_ONE;
                            if (r_count == c_CNT_ONE) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                                r_state <= c_CHECK;
`else
                                r_state <= c_FINISH;
`endif
                            end
                        end
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    c_CHECK: begin
                        if (w_xfer) begin
                            if (w_sumMatch) begin
                                r_state <= c_FINISH;
                            end else begin
                                r_state     <= c_ERROR;
                                r_loadError <= 1'b1;
                            end
                        end
                    end
`endif
                    c_FINISH: begin
                        // Bubble lets the final write land before any fetch.
                        r_state <= c_DONE;
                        cpuRun  <= 1'b1;
                    end
                    c_IDLE, c_DONE, c_ERROR: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        cpuRun  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
